// File: rtl/bus_master_port.sv
// Host-side bus master: turns one parallel read/write request into the serial
// breq/grant, address, data, ack and split protocol, returning a one-cycle response.
//
// state      | meaning
// IDLE       | waiting for a host request, req_ready=1
// REQ        | breq=1, waiting for two consecutive grant cycles
// ADDR_DEV   | shifting out the device-select address bits
// ACK_WAIT   | waiting for the addressed slave to ack, bounded by a timer
// ADDR_MEM   | shifting out the remaining address bits
// WDATA      | shifting out write data
// RDATA      | shifting in read data
// SPLIT_WAIT | slave split the transfer; hold breq and resume when released
// RESP       | one-cycle response pulse
// COOL       | breq low two cycles so the arbiter can return to idle
`timescale 1ns/1ps
module bus_master_port #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEV_BITS    = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  breq,
  input  logic                  bgrant,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  input  logic                  slave_ready,
  output logic                  master_ready,
  input  logic                  slave_valid,
  input  logic                  rd_bus,
  input  logic                  ack,
  input  logic                  split
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] DEV_LAST  = CNT_W'(DEV_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TMR_W-1:0] TMR_INIT  = TMR_W'(ACK_TIMEOUT - 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_REQ        = 4'd1;
  localparam logic [3:0] S_ADDR_DEV   = 4'd2;
  localparam logic [3:0] S_ACK_WAIT   = 4'd3;
  localparam logic [3:0] S_ADDR_MEM   = 4'd4;
  localparam logic [3:0] S_WDATA      = 4'd5;
  localparam logic [3:0] S_RDATA      = 4'd6;
  localparam logic [3:0] S_SPLIT_WAIT = 4'd7;
  localparam logic [3:0] S_RESP       = 4'd8;
  localparam logic [3:0] S_COOL       = 4'd9;

  logic [3:0]            state;
  logic [3:0]            resume_state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_inc;
  logic [TMR_W-1:0]      ack_tmr;
  logic                  grant_seen;
  logic                  cool_cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_sh;

  assign bit_inc = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;

  assign req_ready    = (state == S_IDLE);
  assign breq         = (state >= S_REQ) && (state <= S_SPLIT_WAIT);
  assign mode         = breq & wr_q;
  assign master_valid = (state == S_ADDR_DEV) || (state == S_ADDR_MEM) || (state == S_WDATA);
  assign master_ready = (state == S_RDATA);
  assign wr_bus       = master_valid &
                        ((state == S_WDATA) ? wdata_sh[DATA_WIDTH-1] : addr_sh[ADDR_WIDTH-1]);
  assign rsp_valid    = (state == S_RESP);
  assign rsp_err      = rsp_valid & err_q;
  assign rsp_rdata    = (rsp_valid && !err_q && !wr_q) ? rdata_sh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      resume_state <= S_IDLE;
      bit_cnt      <= '0;
      ack_tmr      <= '0;
      grant_seen   <= 1'b0;
      cool_cnt     <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_sh      <= '0;
      wdata_sh     <= '0;
      rdata_sh     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wr_q       <= req_wr;
            addr_sh    <= req_addr;
            wdata_sh   <= req_wdata;
            rdata_sh   <= '0;
            err_q      <= 1'b0;
            bit_cnt    <= '0;
            grant_seen <= 1'b0;
            state      <= S_REQ;
          end
        end
        // a single grant cycle may be left over from the previous owner
        S_REQ: begin
          if (bgrant) begin
            grant_seen <= 1'b1;
            if (grant_seen) state <= S_ADDR_DEV;
          end else begin
            grant_seen <= 1'b0;
          end
        end
        S_ADDR_DEV: begin
          if (!bgrant) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (slave_ready) begin
            addr_sh <= {addr_sh[ADDR_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_inc;
            if (bit_cnt == DEV_LAST) begin
              ack_tmr <= TMR_INIT;
              state   <= S_ACK_WAIT;
            end
          end
        end
        S_ACK_WAIT: begin
          if (!bgrant) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (ack) begin
            state <= S_ADDR_MEM;
          end else if (ack_tmr == '0) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            ack_tmr <= ack_tmr - 1'b1;
          end
        end
        // split is checked ahead of grant loss and the handshake: the bit is not consumed
        S_ADDR_MEM: begin
          if (split) begin
            resume_state <= S_ADDR_MEM;
            state        <= S_SPLIT_WAIT;
          end else if (!bgrant) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (slave_ready) begin
            addr_sh <= {addr_sh[ADDR_WIDTH-2:0], 1'b0};
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= wr_q ? S_WDATA : S_RDATA;
            end else begin
              bit_cnt <= bit_inc;
            end
          end
        end
        S_WDATA: begin
          if (split) begin
            resume_state <= S_WDATA;
            state        <= S_SPLIT_WAIT;
          end else if (!bgrant) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (slave_ready) begin
            wdata_sh <= {wdata_sh[DATA_WIDTH-2:0], 1'b0};
            bit_cnt  <= bit_inc;
            if (bit_cnt == DATA_LAST) state <= S_RESP;
          end
        end
        S_RDATA: begin
          if (split) begin
            resume_state <= S_RDATA;
            state        <= S_SPLIT_WAIT;
          end else if (!bgrant) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (slave_valid) begin
            rdata_sh <= {rdata_sh[DATA_WIDTH-2:0], rd_bus};
            bit_cnt  <= bit_inc;
            if (bit_cnt == DATA_LAST) state <= S_RESP;
          end
        end
        S_SPLIT_WAIT: begin
          if (!split && bgrant) state <= resume_state;
        end
        S_RESP: begin
          cool_cnt <= 1'b1;
          state    <= S_COOL;
        end
        S_COOL: begin
          if (cool_cnt == 1'b0) state <= S_IDLE;
          else cool_cnt <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: a reactive arbiter/slave model drives the
// serial side, responses are predicted at issue time and checked by a monitor.
`timescale 1ns/1ps
module tb_bus_master_port;
  localparam int AW = 16;
  localparam int DB = 5;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          req;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          breq;
  logic          bgrant;
  logic          mode;
  logic          wr_bus;
  logic          master_valid;
  logic          slave_ready;
  logic          master_ready;
  logic          slave_valid;
  logic          rd_bus;
  logic          ack;
  logic          split;

  bus_master_port #(.ADDR_WIDTH(AW), .DEV_BITS(DB), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .breq(breq), .bgrant(bgrant),
    .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid), .slave_ready(slave_ready),
    .master_ready(master_ready), .slave_valid(slave_valid), .rd_bus(rd_bus),
    .ack(ack), .split(split)
  );

  typedef struct {
    logic        err;
    logic [7:0]  rdata;
    logic [31:0] bits;
    int          nbits;
    int          aw;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int issued = 0;
  int rsp_cyc = 0;
  int t_issue = 0;
  logic go = 1'b0;

  // scenario knobs read by the arbiter/slave model
  logic       sc_ideal, sc_ack, sc_gloss, sc_split, sc_gpat_en, cur_wr;
  logic [3:0] gpat_sh;
  logic [7:0] sc_rdata, rd_sh;
  int         sc_ack_dly, sc_gloss_at, sc_split_at, sc_split_len;
  logic [31:0] cap;
  int         ncap, aw_cnt, bit_now;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected event (cycle %0d)", nm, cyc);
  endtask

  // arbiter + slave model, decides inputs for the next rising edge
  initial begin : bfm
    int   tot, req_cycles, sp_ph;
    logic est, prev_g, lost, sp_done, gate_pending, g;
    bgrant = 0; slave_ready = 0; slave_valid = 0; rd_bus = 0; ack = 0; split = 0;
    tot = 0; req_cycles = 0; sp_ph = 0; est = 0; prev_g = 0; lost = 0;
    sp_done = 0; gate_pending = 0; bit_now = -1;
    forever begin
      @(negedge clk);
      ack = 0; split = 0; slave_ready = 0; slave_valid = 0; rd_bus = 1'($urandom);
      if (rst || !breq) begin
        bgrant = 0; tot = 0; req_cycles = 0; sp_ph = 0; est = 0; prev_g = 0;
        lost = 0; sp_done = 0; gate_pending = 0; bit_now = -1;
      end else if (!est) begin
        chk("grant_gate", 32'(master_valid), 32'd0);
        if (sc_gpat_en && req_cycles < 4) begin
          g = gpat_sh[0];
          gpat_sh = gpat_sh >> 1;
        end else begin
          g = sc_ideal || ($urandom_range(0, 9) < 7);
        end
        bgrant = g;
        req_cycles++;
        if (g && prev_g) begin
          est = 1;
          gate_pending = 1;
        end
        prev_g = g;
      end else begin
        bit_now = tot;
        bgrant = 1;
        if (gate_pending) begin
          chk("grant_gate_open", 32'(master_valid), 32'd1);
          gate_pending = 0;
        end
        if (lost) begin
          bgrant = 0;
        end else if (sp_ph > 0) begin
          chk("split_hold", 32'({master_valid, master_ready, breq}), 32'd1);
          if (sp_ph < sc_split_len) begin
            split = 1; bgrant = 0; sp_ph++;
          end else if (sp_ph == sc_split_len) begin
            bgrant = 0; sp_ph++;
          end else begin
            sp_ph = 0; sp_done = 1;
          end
        end else if (sc_gloss && tot == sc_gloss_at) begin
          lost = 1; bgrant = 0;
        end else if (sc_split && !sp_done && tot == sc_split_at && (master_valid || master_ready)) begin
          split = 1; sp_ph = 1;
        end else begin
          if (!master_valid && !master_ready && tot == DB) begin
            aw_cnt++;
            ack = sc_ack && (aw_cnt > sc_ack_dly);
          end
          if (master_valid) begin
            slave_ready = sc_ideal || ($urandom_range(0, 9) < 7);
            if (slave_ready) begin
              cap = {cap[30:0], wr_bus};
              ncap++;
              tot++;
            end
          end
          if (master_ready) begin
            slave_valid = sc_ideal || ($urandom_range(0, 9) < 7);
            if (slave_valid) begin
              rd_bus = rd_sh[7];
              rd_sh = {rd_sh[6:0], 1'b0};
              tot++;
            end
          end
        end
      end
    end
  end

  // response monitor
  initial begin : mon
    exp_t e;
    logic prev_v;
    logic [31:0] mask;
    prev_v = 0;
    wait (go);
    forever begin
      @(negedge clk);
      chk("mode", 32'(mode), breq ? 32'(cur_wr) : 32'd0);
      if (rsp_valid) begin
        rsp_cyc = cyc;
        if (prev_v) fail("rsp_pulse_width");
        else if (sb.size() == 0) fail("unexpected_rsp");
        else begin
          e = sb.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          if (e.nbits >= 0) begin
            mask = (32'd1 << e.nbits) - 32'd1;
            chk("wr_bus_count", 32'(ncap), 32'(e.nbits));
            chk("wr_bus_bits", cap & mask, e.bits);
          end
          if (e.aw >= 0) chk("ack_wait_cycles", 32'(aw_cnt), 32'(e.aw));
          done_cnt++;
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic set_ideal(input logic [7:0] rdata);
    sc_ideal = 1; sc_ack = 1; sc_gloss = 0; sc_split = 0; sc_gpat_en = 0;
    sc_ack_dly = 0; sc_gloss_at = 0; sc_split_at = 0; sc_split_len = 1; sc_rdata = rdata;
  endtask

  task automatic set_rand();
    int k;
    k = $urandom_range(0, 9);
    sc_ideal = 0; sc_gpat_en = 0;
    sc_ack = (k != 0); sc_gloss = (k == 1); sc_split = (k == 2 || k == 3);
    sc_ack_dly = $urandom_range(0, TO - 1);
    sc_gloss_at = $urandom_range(0, AW + DW - 1);
    sc_split_at = $urandom_range(DB, AW + DW - 1);
    sc_split_len = $urandom_range(1, 6);
    sc_rdata = 8'($urandom);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    exp_t e;
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("ready_timeout");
    cap = 0; ncap = 0; aw_cnt = 0; cur_wr = wr; rd_sh = sc_rdata; gpat_sh = 4'b1101;
    e.err = !sc_ack || sc_gloss;
    e.rdata = (e.err || wr) ? 8'h00 : sc_rdata;
    if (sc_gloss) begin
      e.nbits = -1; e.aw = -1; e.bits = 0;
    end else if (!sc_ack) begin
      e.nbits = DB; e.aw = TO; e.bits = 32'(a >> (AW - DB));
    end else begin
      e.nbits = wr ? AW + DW : AW;
      e.aw = sc_ack_dly + 1;
      e.bits = wr ? {8'h00, a, d} : {16'h0000, a};
    end
    sb.push_back(e);
    issued++;
    t_issue = cyc;
    req = 1; req_wr = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    repeat (hold) begin
      req_wr = ~wr; req_addr = AW'($urandom); req_wdata = DW'($urandom);
      @(negedge clk);
    end
    req = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < issued && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < issued) begin
      fail("rsp_timeout");
      done_cnt = issued;
      sb.delete();
    end
  endtask

  initial begin : stim
    int n;
    rst = 1; req = 0; req_wr = 0; req_addr = 0; req_wdata = 0; cur_wr = 0;
    cap = 0; ncap = 0; aw_cnt = 0; rd_sh = 0; gpat_sh = 0;
    set_ideal(8'h00);
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({req_ready, breq, mode, wr_bus, master_valid, master_ready, rsp_valid, rsp_err}),
        32'b1000_0000);
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    rst = 0;
    go = 1;

    set_ideal(8'h00);
    issue(1'b1, 16'h0123, 8'hA5, 0);
    wait_done();
    chk("write_latency", 32'(rsp_cyc - t_issue), 32'd28);

    set_ideal(8'h3C);
    issue(1'b0, 16'h2004, 8'h00, 0);
    wait_done();
    chk("read_latency", 32'(rsp_cyc - t_issue), 32'd28);

    set_ideal(8'h00);
    sc_ack = 0;
    issue(1'b0, 16'hF800, 8'h00, 0);
    n = 0;
    while (!breq && n < 50) begin @(negedge clk); n++; end
    while (breq && n < 100) begin @(negedge clk); n++; end
    if (breq) fail("noack_breq_timeout");
    n = 0;
    while (!req_ready && n < 10) begin
      chk("noack_breq_low", 32'(breq), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("noack_cool_cycles", 32'(n), 32'd3);
    wait_done();

    set_ideal(8'h96);
    sc_split = 1; sc_split_at = AW + 3; sc_split_len = 20;
    issue(1'b0, 16'h4A5C, 8'h00, 0);
    wait_done();

    set_ideal(8'h00);
    sc_gpat_en = 1;
    issue(1'b1, 16'h8421, 8'h5A, 0);
    wait_done();
    chk("glitch_grant_latency", 32'(rsp_cyc - t_issue), 32'd30);

    for (int i = 0; i < 40; i++) begin
      set_rand();
      issue(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 3));
      wait_done();
    end

    set_ideal(8'h00);
    issue(1'b1, 16'h1357, 8'hC3, 0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(bit_now == AW + 4 && master_valid) && n < 100);
    if (n >= 100) fail("wdata_bit4_timeout");
    rst = 1;
    @(negedge clk);
    chk("rst_mid_xfer", 32'({breq, master_valid, req_ready, rsp_valid}), 32'b0010);
    rst = 0;
    void'(sb.pop_back());
    issued--;
    repeat (10) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
